// File: rtl/mux_rr_arb_pkg.sv
// Shared definitions for the mux_rr_arb select stage: arbitration mode codes,
// output-buffer state encoding and the clog2 helper used for the SEL_W check.
package mux_rr_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_rr_arb_rr_arbiter.sv
// Combinational arbiter: lowest-index-first in fixed mode, or first requester
// at/after rr_ptr (wrapping) in round-robin mode. Produces one-hot grant + index.
module rr_arbiter
  import mux_rr_arb_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic             mode,
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic [N_IN-1:0]  req,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_any
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    idx_s     = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = (mode == MODE_RR) ? (int'(rr_ptr) + k) : k;
      if (idx >= N_IN) begin
        idx = idx - N_IN;
      end
      idx_s = SEL_W'(idx);
      if (!grant_any && req[idx_s]) begin
        grant_any    = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-input valid/ready select stage with a one-entry registered output buffer.
// Optional packet locking (in_last port) is enabled by defining MUX_LOCK_EN.
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
`ifdef MUX_LOCK_EN
  input  logic [N_IN-1:0]       in_last,
`endif
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  generate
    if (SEL_W != clog2_f(N_IN) || N_IN < 2 || N_IN > 16) begin : g_param_check
      $error("mux_rr_arb: N_IN must be 2..16 and SEL_W must equal clog2(N_IN)");
    end
  endgenerate

  buf_state_e       state_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_ptr_d;

  logic [WIDTH-1:0] ch_data [N_IN];
  logic [N_IN-1:0]  req;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_any;
  logic             load_en;
  logic             load;
  logic             last_beat;
  logic             advance;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch_data
    assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

`ifdef MUX_LOCK_EN
  logic             lock_q;
  logic [N_IN-1:0]  lock_mask;

  // While locked only the channel that owns the packet (held in out_sel_q) may request.
  always_comb begin
    lock_mask            = '0;
    lock_mask[out_sel_q] = 1'b1;
  end

  assign req       = lock_q ? (in_valid & lock_mask) : in_valid;
  assign last_beat = in_last[grant_idx];
`else
  assign req       = in_valid;
  assign last_beat = 1'b1;
`endif

  rr_arbiter #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .mode      (mode),
    .rr_ptr    (rr_ptr_q),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign load_en  = (state_q == BUF_EMPTY) | out_ready;
  assign load     = load_en & grant_any & ~reset;
  assign in_ready = (load_en & ~reset) ? grant : '0;
  assign advance  = load & (mode == MODE_RR) & last_beat;
  assign rr_ptr_d = (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      rr_ptr_q   <= '0;
`ifdef MUX_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        BUF_EMPTY: if (load) state_q <= BUF_FULL;
        BUF_FULL:  if (!load && out_ready) state_q <= BUF_EMPTY;
        default:   state_q <= BUF_EMPTY;
      endcase
      if (load) begin
        out_data_q <= ch_data[grant_idx];
        out_sel_q  <= grant_idx;
      end
      if (advance) begin
        rr_ptr_q <= rr_ptr_d;
      end
`ifdef MUX_LOCK_EN
      if (load) begin
        lock_q <= ~last_beat;
      end
`endif
    end
  end

  assign out_valid = (state_q == BUF_FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
